div_iter: RTL



---
 rtl/div_iter.sv | 172 +++++++++++++++++
 1 files changed

// File: rtl/div_iter.sv
// -----------------------------------------------------------------------------
// div_iter -- multi-cycle radix-2 restoring divider for the EX stage.
//
// EX raises start_i with signedness and operands and stalls until ready_o.
// The divider latches operand magnitudes, resolves one quotient bit per clock,
// then returns {remainder, quotient} (MIPS HI/LO) with ready_o held high until
// EX drops start_i. annul_i flushes the operation from any non-idle state.
//
// Ports
//   clk           clock, rising edge
//   resetn        asynchronous reset, active-low
//   signed_div_i  1 = DIV (signed), 0 = DIVU; sampled with start_i
//   opdata1_i     dividend; sampled with start_i
//   opdata2_i     divisor;  sampled with start_i
//   start_i       request, held high until ready_o is seen
//   annul_i       abort the current operation
//   result_o      [2W-1:W] remainder, [W-1:0] quotient (registered)
//   ready_o       result valid (registered)
// -----------------------------------------------------------------------------
module div_iter #(
    parameter int WIDTH = 32
) (
    input  logic               clk,
    input  logic               resetn,
    input  logic               signed_div_i,
    input  logic [WIDTH-1:0]   opdata1_i,
    input  logic [WIDTH-1:0]   opdata2_i,
    input  logic               start_i,
    input  logic               annul_i,
    output logic [2*WIDTH-1:0] result_o,
    output logic               ready_o
);

    localparam int            CW   = $clog2(WIDTH);
    localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_DIVZERO,
        ST_ON,
        ST_END
    } state_t;

    state_t                 state, state_nxt;
    logic [CW-1:0]          cnt;
    logic                   neg_quo;
    logic                   neg_rem;
    logic [WIDTH-1:0]       dvd;      // dividend magnitude; quotient bits shift in from the right
    logic [WIDTH-1:0]       dvs;      // divisor magnitude
    logic [WIDTH-1:0]       rem;      // partial remainder

    logic signed [WIDTH+1:0] trial;
    logic                    q_bit;
    logic [WIDTH-1:0]        rem_step;
    logic [WIDTH-1:0]        quo_step;
    logic                    op1_neg;
    logic                    op2_neg;
    logic                    accept;

    // Two's-complement negate when requested. The most negative value maps onto
    // itself, which is exactly the wrapped result wanted for -2^(W-1) / -1.
    function automatic logic [WIDTH-1:0] cond_neg(input logic [WIDTH-1:0] v,
                                                  input logic             en);
        return en ? (~v) + WIDTH'(1) : v;
    endfunction

    assign op1_neg = signed_div_i & opdata1_i[WIDTH-1];
    assign op2_neg = signed_div_i & opdata2_i[WIDTH-1];
    assign accept  = start_i & ~annul_i;

    // One restoring step. The partial remainder is always below the divisor,
    // so the shifted value fits in W+1 bits and the extra top bit is the sign.
    always_comb begin
        trial    = $signed({1'b0, rem, dvd[WIDTH-1]} - {2'b00, dvs});
        q_bit    = (trial >= 0);
        rem_step = q_bit ? trial[WIDTH-1:0] : {rem[WIDTH-2:0], dvd[WIDTH-1]};
        quo_step = {dvd[WIDTH-2:0], q_bit};
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state <= ST_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            ST_IDLE: begin
                if (accept) begin
                    state_nxt = (opdata2_i == '0) ? ST_DIVZERO : ST_ON;
                end
            end
            ST_ON: begin
                if (annul_i) begin
                    state_nxt = ST_IDLE;
                end else if (cnt == LAST) begin
                    state_nxt = ST_END;
                end
            end
            ST_DIVZERO: begin
                state_nxt = annul_i ? ST_IDLE : ST_END;
            end
            ST_END: begin
                if (annul_i || !start_i) begin
                    state_nxt = ST_IDLE;
                end
            end
            default: state_nxt = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            cnt      <= '0;
            neg_quo  <= 1'b0;
            neg_rem  <= 1'b0;
            dvd      <= '0;
            dvs      <= '0;
            rem      <= '0;
            result_o <= '0;
            ready_o  <= 1'b0;
        end else begin
            case (state)
                ST_IDLE: begin
                    result_o <= '0;
                    ready_o  <= 1'b0;
                    if (accept && (opdata2_i != '0)) begin
                        neg_quo <= op1_neg ^ op2_neg;
                        neg_rem <= op1_neg;
                        dvd     <= cond_neg(opdata1_i, op1_neg);
                        dvs     <= cond_neg(opdata2_i, op2_neg);
                        rem     <= '0;
                        cnt     <= '0;
                    end
                end
                ST_ON: begin
                    if (annul_i) begin
                        result_o <= '0;
                        ready_o  <= 1'b0;
                    end else begin
                        rem <= rem_step;
                        dvd <= quo_step;
                        cnt <= cnt + CW'(1);
                        if (cnt == LAST) begin
                            result_o <= {cond_neg(rem_step, neg_rem),
                                         cond_neg(quo_step, neg_quo)};
                            ready_o  <= 1'b1;
                        end
                    end
                end
                ST_DIVZERO: begin
                    result_o <= '0;
                    ready_o  <= ~annul_i;
                end
                ST_END: begin
                    if (annul_i || !start_i) begin
                        result_o <= '0;
                        ready_o  <= 1'b0;
                    end
                end
                default: begin
                    result_o <= '0;
                    ready_o  <= 1'b0;
                end
            endcase
        end
    end

endmodule
